bank_playback_reader: RTL and testbench

Downstream consumer of the ping-pong sample bank memory. It detects each bank swap on current_bank, then drains the completed (read-side) bank sample by sample, addresses 0 to NUM_SAMPLES-1, at a fixed rate set by TICK_DIV. Samples go out through a valid/ready register toward the DAC/PWM stage, and the block flags a sticky overrun if the writer swaps banks before draining finishes.

---
 rtl/sample_pkg.sv | 17 +
 rtl/bank_playback_reader_if.sv | 28 ++
 rtl/rate_tick_gen.sv | 31 +++
 rtl/bank_playback_reader.sv | 101 ++++++++++
 tb/tb_bank_playback_reader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_pkg.sv
// sample_pkg: shared constants for the sample bank playback path.
//   NUM_SAMPLES / ADDR_W / DATA_W : bank geometry and sample width
//   TICK_DIV_DEFAULT              : sys_clk cycles per output sample (12 MHz / 32 kHz)
//   IDLE / WAIT_TICK / READ / CAPTURE : playback FSM state encoding
package sample_pkg;

  localparam int NUM_SAMPLES      = 512;
  localparam int ADDR_W           = 9;
  localparam int DATA_W           = 8;
  localparam int TICK_DIV_DEFAULT = 375;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_TICK = 2'd1;
  localparam logic [1:0] READ      = 2'd2;
  localparam logic [1:0] CAPTURE   = 2'd3;

endpackage

// File: rtl/bank_playback_reader_if.sv
// bank_playback_reader_if: memory read port plus output sample stream.
//   read_request / read_address : one-cycle read strobe and address to the bank memory
//   rd_data                     : memory data, valid the cycle after read_request
//   sample_out / sample_valid / sample_ready : output stream toward the DAC/PWM stage
// Stream handshake: a sample transfers on every cycle where sample_valid and
// sample_ready are both high; while sample_valid is high and sample_ready is
// low, sample_out holds its value and sample_valid stays high.
// Modports: master = playback reader side, slave = memory/downstream side.
interface bank_playback_reader_if;

  logic                          read_request;
  logic [sample_pkg::ADDR_W-1:0] read_address;
  logic [sample_pkg::DATA_W-1:0] rd_data;
  logic [sample_pkg::DATA_W-1:0] sample_out;
  logic                          sample_valid;
  logic                          sample_ready;

  modport master (
    output read_request, read_address, sample_out, sample_valid,
    input  rd_data, sample_ready
  );

  modport slave (
    input  read_request, read_address, sample_out, sample_valid,
    output rd_data, sample_ready
  );

endinterface

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: stallable up-counter that saturates at TERM.
//   clk, rst  : clock and synchronous active-high reset
//   clear     : force the count back to zero (wins over enable)
//   enable    : advance by one per cycle while below TERM
//   terminal  : count currently equals TERM
module rate_tick_gen #(
  parameter int TERM = 5,
  parameter int W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TERM_V)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERM_V);

endmodule

// File: rtl/bank_playback_reader.sv
// bank_playback_reader: drains the completed ping-pong bank after each swap.
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   current_bank     : bank being written; any change marks a swap
//   bus (master)     : memory read port and output sample stream
//   busy             : a bank drain is in progress
//   overrun          : sticky, a swap arrived while a drain was in progress
//   fsm_state        : current playback state (IDLE/WAIT_TICK/READ/CAPTURE)
// Each sample costs TICK_DIV cycles: TICK_DIV-2 in WAIT_TICK, one READ, one CAPTURE.
module bank_playback_reader
  import sample_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  current_bank,
  bank_playback_reader_if.master bus,
  output logic                  busy,
  output logic                  overrun,
  output logic [1:0]            fsm_state
);

  localparam int              TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              bank_q;
  logic              swap;
  logic              reg_free;
  logic              load;
  logic              tick_done;

  assign swap     = current_bank ^ bank_q;
  assign reg_free = !bus.sample_valid || bus.sample_ready;
  // A swap during CAPTURE discards the in-flight read.
  assign load     = (state == CAPTURE) && !swap;

  // Terminal at TICK_DIV-3 leaves room for READ and CAPTURE within the period.
  rate_tick_gen #(
    .TERM (TICK_DIV - 3),
    .W    (TICK_W)
  ) u_tick (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .clear    (swap || load),
    .enable   (state == WAIT_TICK),
    .terminal (tick_done)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      addr    <= '0;
      bank_q  <= current_bank;
      overrun <= 1'b0;
    end else begin
      bank_q <= current_bank;
      if (swap) begin
        // Swap beats every other transition and always restarts the drain.
        if (state != IDLE) overrun <= 1'b1;
        addr  <= '0;
        state <= WAIT_TICK;
      end else begin
        case (state)
          IDLE:      state <= IDLE;
          WAIT_TICK: if (tick_done && reg_free) state <= READ;
          READ:      state <= CAPTURE;
          CAPTURE: begin
            if (addr == LAST_ADDR) begin
              state <= IDLE;
            end else begin
              addr  <= addr + 1'b1;
              state <= WAIT_TICK;
            end
          end
          default:   state <= IDLE;
        endcase
      end
    end
  end

  // Output register: a reload in the same cycle as a transfer keeps valid high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else if (load) begin
      bus.sample_out   <= bus.rd_data;
      bus.sample_valid <= 1'b1;
    end else if (bus.sample_valid && bus.sample_ready) begin
      bus.sample_valid <= 1'b0;
    end
  end

  assign bus.read_request = (state == READ) && !swap;
  assign bus.read_address = addr;
  assign busy             = (state != IDLE);
  assign fsm_state        = state;

endmodule

// File: tb/tb_bank_playback_reader.sv
// tb_bank_playback_reader: directed scenarios plus a randomized phase for
// bank_playback_reader, checked against an event-level model of drain timing,
// read addresses, sample ordering, busy and overrun.
module tb_bank_playback_reader;
  import sample_pkg::*;

  localparam int TD = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       current_bank = 1'b0;
  logic       busy;
  logic       overrun;
  logic [1:0] fsm_state;

  bank_playback_reader_if bus();

  bank_playback_reader #(.TICK_DIV(TD)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .current_bank (current_bank),
    .bus          (bus.master),
    .busy         (busy),
    .overrun      (overrun),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- bank memory model ----------------
  logic [DATA_W-1:0] mem [NUM_SAMPLES];

  always @(posedge sys_clk) begin
    if (bus.read_request) bus.rd_data <= mem[bus.read_address];
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rr_cnt  = 0;
  int xfer_cnt = 0;
  logic chk_en = 1'b0;

  logic              m_bank_q = 1'b0;
  logic              m_busy   = 1'b0;
  logic              m_ovr    = 1'b0;
  int                exp_addr = 0;
  int                exp_rr_cyc = 0;
  logic              pend_v = 1'b0;
  int                pend_a = 0;
  logic [DATA_W-1:0] pend_d = '0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a drain is a sequence of reads spaced TICK_DIV apart,
  // the first one TICK_DIV-1 cycles after the swap; a read whose terminal
  // cycle finds the output register full slides one cycle later.
  always @(negedge sys_clk) begin
    logic swap_m;
    logic exp_rr;
    logic free_m;
    logic xfer_m;
    cyc++;
    swap_m = (current_bank !== m_bank_q);
    exp_rr = m_busy && !swap_m && (cyc == exp_rr_cyc);
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ovr);
      check("valid", bus.sample_valid, exp_q.size() != 0);
      check("rd_req", bus.read_request, exp_rr);
      if (bus.read_request) check("rd_addr", bus.read_address, exp_addr);
      if (bus.sample_valid && exp_q.size() != 0) check("sample", bus.sample_out, exp_q[0]);
    end
    if (bus.read_request) rr_cnt++;
    if (bus.sample_valid && bus.sample_ready) xfer_cnt++;
    free_m = (exp_q.size() == 0) || bus.sample_ready;
    xfer_m = (exp_q.size() != 0) && bus.sample_ready;
    if (sys_rst) begin
      m_busy = 1'b0;
      m_ovr  = 1'b0;
      exp_q.delete();
      pend_v = 1'b0;
      exp_addr = 0;
    end else begin
      if (xfer_m) void'(exp_q.pop_front());
      if (pend_v && !swap_m) begin
        exp_q.push_back(pend_d);
        if (pend_a == NUM_SAMPLES - 1) m_busy = 1'b0;
        exp_addr = pend_a + 1;
      end
      pend_v = 1'b0;
      if (swap_m) begin
        if (m_busy) m_ovr = 1'b1;
        m_busy = 1'b1;
        exp_addr = 0;
        exp_rr_cyc = cyc + TD - 1;
      end else if (exp_rr) begin
        pend_v = 1'b1;
        pend_a = exp_addr;
        pend_d = mem[exp_addr];
        exp_rr_cyc = cyc + TD;
      end else if (m_busy && (cyc == exp_rr_cyc - 1) && !free_m) begin
        exp_rr_cyc++;
      end
    end
    m_bank_q = current_bank;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) tick();
    sys_rst = 1'b0;
  endtask

  task automatic toggle_bank();
    current_bank = ~current_bank;
  endtask

  task automatic wait_rr(input int a, input int bound, input string tag);
    int k = 0;
    while (!(bus.read_request && (bus.read_address == ADDR_W'(a))) && k < bound) begin
      tick();
      k++;
    end
    check(tag, k < bound, 1'b1);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    tick();
    while (busy && k < bound) begin
      tick();
      k++;
    end
    check(tag, k < bound, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    int x0;
    int k;
    bus.sample_ready = 1'b1;
    for (int i = 0; i < NUM_SAMPLES; i++) mem[i] = i[DATA_W-1:0];

    // 1: reset with current_bank high, then idle.
    tick();
    current_bank = 1'b1;
    do_reset(2);
    chk_en = 1'b1;
    check("rst_rd_req", bus.read_request, 1'b0);
    check("rst_rd_addr", bus.read_address, 0);
    check("rst_sample_out", bus.sample_out, 0);
    check("rst_valid", bus.sample_valid, 1'b0);
    r0 = rr_cnt;
    repeat (100) tick();
    check("idle_no_rr", rr_cnt - r0, 0);
    check("idle_busy", busy, 1'b0);
    check("idle_overrun", overrun, 1'b0);

    // 2: full drain with downstream always ready.
    r0 = rr_cnt;
    x0 = xfer_cnt;
    toggle_bank();
    wait_idle(NUM_SAMPLES * TD + 50, "drain_done");
    repeat (4) tick();
    check("drain_reads", rr_cnt - r0, NUM_SAMPLES);
    check("drain_xfers", xfer_cnt - x0, NUM_SAMPLES);
    check("drain_overrun", overrun, 1'b0);

    // 3: backpressure on the first sample.
    bus.sample_ready = 1'b0;
    toggle_bank();
    k = 0;
    while (!bus.sample_valid && k < 2 * TD + 5) begin
      tick();
      k++;
    end
    check("bp_first_valid", bus.sample_valid, 1'b1);
    r0 = rr_cnt;
    repeat (50) begin
      tick();
      check("bp_hold", bus.sample_out, 8'h00);
    end
    check("bp_no_rr", rr_cnt - r0, 0);
    bus.sample_ready = 1'b1;
    k = 0;
    while (!bus.read_request && k < TD - 2) begin
      tick();
      k++;
    end
    check("bp_resume_rr", bus.read_request, 1'b1);
    check("bp_resume_addr", bus.read_address, 1);

    // 4: swap while draining, landing on the CAPTURE of address 100.
    wait_rr(100, 101 * TD + 20, "ovr_reach_100");
    tick();
    toggle_bank();
    tick();
    check("ovr_set", overrun, 1'b1);
    check("ovr_no_capture", bus.sample_valid, 1'b0);
    check("ovr_busy", busy, 1'b1);
    wait_rr(0, TD + 5, "ovr_restart_0");
    repeat (20) tick();
    check("ovr_sticky", overrun, 1'b1);
    do_reset(2);
    check("ovr_cleared", overrun, 1'b0);

    // 5: swap coinciding with the final CAPTURE.
    toggle_bank();
    wait_rr(NUM_SAMPLES - 1, NUM_SAMPLES * TD + 50, "last_reach_511");
    tick();
    toggle_bank();
    tick();
    check("last_ovr", overrun, 1'b1);
    check("last_busy", busy, 1'b1);
    wait_rr(0, TD + 5, "last_restart_0");
    do_reset(2);

    // 6: reset in the middle of a drain.
    toggle_bank();
    wait_rr(37, 38 * TD + 20, "mid_reach_37");
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("mid_rd_req", bus.read_request, 1'b0);
    check("mid_rd_addr", bus.read_address, 0);
    check("mid_sample_out", bus.sample_out, 0);
    check("mid_valid", bus.sample_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_overrun", overrun, 1'b0);
    r0 = rr_cnt;
    repeat (50) tick();
    check("mid_no_rr", rr_cnt - r0, 0);

    // Randomized phase: random memory, random backpressure, random swaps.
    for (int i = 0; i < NUM_SAMPLES; i++) mem[i] = DATA_W'($urandom);
    toggle_bank();
    for (int i = 0; i < 9000; i++) begin
      tick();
      bus.sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2499) == 0) toggle_bank();
    end
    bus.sample_ready = 1'b1;
    wait_idle(NUM_SAMPLES * TD + 50, "rand_done");
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
